// File: rtl/fp_to_fixed_serial.sv
// fp_to_fixed_serial: IEEE-754 single -> signed Q(W-F).F fixed point.
// The significand is shifted one bit per cycle, so latency tracks the
// exponent distance from the fixed-point binary point. Out-of-range values
// saturate and flag ovf; tiny values and zero/denormals flush to 0.
module fp_to_fixed_serial #(
    parameter int W = 32,
    parameter int F = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         ovf,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Shift distance s = exp - (150 - F): exponent bias plus the 23 mantissa
    // bits, offset by the fractional bits of the destination format.
    localparam logic signed [9:0] BIAS   = 10'(150 - F);
    // 23 + s >= W-1 would put the leading one on or above the sign bit.
    localparam logic signed [9:0] SAT_S  = 10'(W - 24);
    // s <= -24 shifts the leading one entirely out of the result.
    localparam logic signed [9:0] ZERO_S = -10'sd24;

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

    state_t         state_q, state_d;
    logic [W-1:0]   mag_q, mag_d;
    logic [9:0]     count_q, count_d;
    logic           left_q, left_d;
    logic           sign_q, sign_d;
    logic [W-1:0]   out_q, out_d;
    logic           ovf_q, ovf_d;

    logic [7:0]          exp_f;
    logic signed [9:0]   s;
    logic [9:0]          abs_s;
    logic [W-1:0]        sig_ext;
    logic [W-1:0]        shifted;
    logic                is_zero;
    logic                is_sat;

    // Two's-complement apply of the sign; a negative zero magnitude stays 0.
    function automatic logic [W-1:0] apply_sign(input logic neg, input logic [W-1:0] m);
        return neg ? ('0 - m) : m;
    endfunction

    // Input-word decode and range classification, evaluated every cycle.
    always_comb begin
        exp_f   = in[30:23];
        s       = $signed({2'b00, exp_f}) - BIAS;
        abs_s   = s[9] ? 10'(-s) : s;
        sig_ext = {{(W-24){1'b0}}, 1'b1, in[22:0]};
        is_sat  = (exp_f == 8'hFF) || (s >= SAT_S);
        is_zero = (exp_f == 8'h00) || (s <= ZERO_S);
        shifted = left_q ? (mag_q << 1) : (mag_q >> 1);
    end

    // Next-state and datapath update for the accept/shift/hold sequence.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        count_d = count_q;
        left_d  = left_q;
        sign_d  = sign_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = in[31];
                    if (is_sat) begin
                        out_d   = in[31] ? MAX_NEG : MAX_POS;
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (is_zero) begin
                        out_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (s == 10'sd0) begin
                        out_d   = apply_sign(in[31], sig_ext);
                        ovf_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        mag_d   = sig_ext;
                        count_d = abs_s;
                        left_d  = ~s[9];
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                mag_d   = shifted;
                count_d = count_q - 10'd1;
                // The final shift and the sign application share one edge, so
                // the result lands together with the DONE transition.
                if (count_q == 10'd1) begin
                    out_d   = apply_sign(sign_q, shifted);
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset drops any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            count_q <= '0;
            left_q  <= 1'b0;
            sign_q  <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            count_q <= count_d;
            left_q  <= left_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_to_fixed_serial.sv
// Directed bench for fp_to_fixed_serial at W=32, F=16.
module tb_fp_to_fixed_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_w;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_w;
    logic        ovf;
    logic        busy;

    int tests = 0;
    int fails = 0;

    fp_to_fixed_serial #(.W(32), .F(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_w),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Presents one word, measures edges until out_valid (accept edge counts
    // as 1), checks the result, and optionally releases it with out_ready.
    task automatic convert(input string tag, input logic [31:0] word,
                           input logic [31:0] exp_out, input logic exp_ovf,
                           input int exp_lat, input bit release_it);
        int n;
        check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
        in_w     = word;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".out"}, {32'd0, out_w}, {32'd0, exp_out});
        check({tag, ".ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
        check({tag, ".busy"}, {63'd0, busy}, 64'd1);
        if (release_it) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({tag, ".released"}, {62'd0, out_valid, in_ready}, 64'd1);
        end
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_w      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst.in_ready",  {63'd0, in_ready},  64'd1);
        check("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst.out",       {32'd0, out_w},     64'd0);
        check("rst.ovf",       {63'd0, ovf},       64'd0);
        check("rst.busy",      {63'd0, busy},      64'd0);

        convert("one",      32'h3F800000, 32'h00010000, 1'b0, 8,  1'b1);
        convert("p100k",    32'h47C35000, 32'h7FFFFFFF, 1'b1, 1,  1'b1);
        convert("n100k",    32'hC7C35000, 32'h80000000, 1'b1, 1,  1'b1);
        convert("tiny",     32'h33800000, 32'h00000000, 1'b0, 1,  1'b1);
        convert("denorm",   32'h00000001, 32'h00000000, 1'b0, 1,  1'b1);
        convert("negzero",  32'h80000000, 32'h00000000, 1'b0, 1,  1'b1);
        convert("s0",       32'h43000000, 32'h00800000, 1'b0, 1,  1'b1);
        convert("left1",    32'h43800000, 32'h01000000, 1'b0, 2,  1'b1);
        convert("max32767", 32'h46FFFE00, 32'h7FFF0000, 1'b0, 8,  1'b1);
        convert("p32768",   32'h47000000, 32'h7FFFFFFF, 1'b1, 1,  1'b1);
        convert("n32768",   32'hC7000000, 32'h80000000, 1'b1, 1,  1'b1);
        convert("inf",      32'h7F800000, 32'h7FFFFFFF, 1'b1, 1,  1'b1);
        convert("nan",      32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1,  1'b1);
        convert("lsb",      32'h37800000, 32'h00000001, 1'b0, 24, 1'b1);
        convert("sub_lsb",  32'h37000000, 32'h00000000, 1'b0, 1,  1'b1);
        convert("neg_trunc",32'hB7C00000, 32'hFFFFFFFF, 1'b0, 24, 1'b1);

        // Result held under back-pressure while a new word is offered.
        convert("m2p5", 32'hC0200000, 32'hFFFD8000, 1'b0, 7, 1'b0);
        in_w     = 32'h3F800000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold.out",       {32'd0, out_w},     {32'd0, 32'hFFFD8000});
            check("hold.out_valid", {63'd0, out_valid}, 64'd1);
            check("hold.in_ready",  {63'd0, in_ready},  64'd0);
        end
        // out_ready with in_valid still high: the word must not be taken here.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release.in_ready", {63'd0, in_ready}, 64'd1);
        check("release.busy",     {63'd0, busy},     64'd0);
        convert("after_hold", 32'h3F800000, 32'h00010000, 1'b0, 8, 1'b1);

        // Reset in the middle of a shifting conversion.
        in_w     = 32'h3F800000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid.busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.out_valid", {63'd0, out_valid}, 64'd0);
        check("abort.out",       {32'd0, out_w},     64'd0);
        check("abort.in_ready",  {63'd0, in_ready},  64'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort.no_stray", {63'd0, seen}, 64'd0);
        convert("post_rst", 32'hC0200000, 32'hFFFD8000, 1'b0, 7, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
